// File: rtl/primitive_rasterizer_if.sv
// Command and pixel-stream bundle between the command side, the rasterizer
// and the framebuffer writer's pixel FIFO.
interface primitive_rasterizer_if;
  logic               start;
  logic               mode;
  logic signed [15:0] x0;
  logic signed [15:0] y0;
  logic signed [15:0] x1;
  logic signed [15:0] y1;
  logic        [31:0] colour;
  logic               busy;
  logic               done;
  logic        [63:0] pixel_data;
  logic               pixel_data_valid;
  logic               pixel_fifo_full;

  modport master (
    output start, mode, x0, y0, x1, y1, colour, pixel_fifo_full,
    input  busy, done, pixel_data, pixel_data_valid
  );

  modport slave (
    input  start, mode, x0, y0, x1, y1, colour, pixel_fifo_full,
    output busy, done, pixel_data, pixel_data_valid
  );
endinterface

// File: rtl/primitive_rasterizer.sv
// Filled-rectangle / Bresenham-line pixel generator feeding the framebuffer
// writer's pixel FIFO; stalls on FIFO full without losing or repeating pixels.
module primitive_rasterizer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic clock,
  input  logic reset,
  primitive_rasterizer_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_RECT   = 3'd2;
  localparam logic [2:0] ST_LINE   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef logic signed [17:0] coord_t;

  localparam coord_t ZERO   = '0;
  localparam coord_t ONE    = 18'sd1;
  localparam coord_t X_LAST = coord_t'(SCREEN_WIDTH - 1);
  localparam coord_t Y_LAST = coord_t'(SCREEN_HEIGHT - 1);

  logic [2:0]  state;
  logic        mode_q;
  coord_t      x0_q, y0_q, x1_q, y1_q;
  logic [31:0] colour_q;

  coord_t cur_x, cur_y;
  coord_t rect_xa, rect_xb, rect_yb;
  coord_t line_dx, line_dy, line_sx, line_sy, line_err;

  // Setup-time geometry, derived from the latched command.
  coord_t norm_xa, norm_xb, norm_ya, norm_yb;
  coord_t clip_xa, clip_xb, clip_ya, clip_yb;
  logic   rect_empty;
  coord_t setup_dx, setup_dy, setup_sx, setup_sy;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    norm_xa    = (x0_q < x1_q) ? x0_q : x1_q;
    norm_xb    = (x0_q < x1_q) ? x1_q : x0_q;
    norm_ya    = (y0_q < y1_q) ? y0_q : y1_q;
    norm_yb    = (y0_q < y1_q) ? y1_q : y0_q;
    clip_xa    = (norm_xa < ZERO)   ? ZERO   : norm_xa;
    clip_xb    = (norm_xb > X_LAST) ? X_LAST : norm_xb;
    clip_ya    = (norm_ya < ZERO)   ? ZERO   : norm_ya;
    clip_yb    = (norm_yb > Y_LAST) ? Y_LAST : norm_yb;
    rect_empty = (norm_xb < ZERO) || (norm_yb < ZERO) ||
                 (norm_xa > X_LAST) || (norm_ya > Y_LAST);

    setup_dx = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    setup_dy = (y1_q >= y0_q) ? (y0_q - y1_q) : (y1_q - y0_q);
    setup_sx = (x0_q < x1_q) ? ONE : -ONE;
    setup_sy = (y0_q < y1_q) ? ONE : -ONE;
  end

  // Per-step line quantities.
  logic   in_screen;
  logic   at_end;
  coord_t e2;
  logic   step_x, step_y;
  coord_t err_next;

  always_comb begin
    in_screen = (cur_x >= ZERO) && (cur_x <= X_LAST) &&
                (cur_y >= ZERO) && (cur_y <= Y_LAST);
    at_end    = (cur_x == x1_q) && (cur_y == y1_q);
    e2        = line_err <<< 1;
    step_x    = (e2 >= line_dy);
    step_y    = (e2 <= line_dx);
    err_next  = line_err + (step_x ? line_dy : ZERO) + (step_y ? line_dx : ZERO);
  end

  logic pixel_valid;
  logic line_advance;

  // Valid is combinational so a full flag raised this cycle blocks this cycle's write.
  assign pixel_valid  = !bus.pixel_fifo_full &&
                        ((state == ST_RECT) || ((state == ST_LINE) && in_screen));
  assign line_advance = (state == ST_LINE) && (!in_screen || !bus.pixel_fifo_full);

  assign bus.pixel_data_valid = pixel_valid;
  assign bus.pixel_data       = {cur_x[15:0], cur_y[15:0], colour_q};
  assign bus.busy             = (state == ST_SETUP) || (state == ST_RECT) || (state == ST_LINE);
  assign bus.done             = (state == ST_FINISH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: datapath registers are reset too, because pixel_data must read zero out of reset.
      state    <= ST_IDLE;
      mode_q   <= 1'b0;
      x0_q     <= ZERO;
      y0_q     <= ZERO;
      x1_q     <= ZERO;
      y1_q     <= ZERO;
      colour_q <= '0;
      cur_x    <= ZERO;
      cur_y    <= ZERO;
      rect_xa  <= ZERO;
      rect_xb  <= ZERO;
      rect_yb  <= ZERO;
      line_dx  <= ZERO;
      line_dy  <= ZERO;
      line_sx  <= ZERO;
      line_sy  <= ZERO;
      line_err <= ZERO;
    end else begin
      // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode_q   <= bus.mode;
            x0_q     <= {{2{bus.x0[15]}}, bus.x0};
            y0_q     <= {{2{bus.y0[15]}}, bus.y0};
            x1_q     <= {{2{bus.x1[15]}}, bus.x1};
            y1_q     <= {{2{bus.y1[15]}}, bus.y1};
            colour_q <= bus.colour;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (mode_q) begin
            cur_x    <= x0_q;
            cur_y    <= y0_q;
            line_dx  <= setup_dx;
            line_dy  <= setup_dy;
            line_sx  <= setup_sx;
            line_sy  <= setup_sy;
            line_err <= setup_dx + setup_dy;
            state    <= ST_LINE;
          end else if (rect_empty) begin
            state <= ST_FINISH;
          end else begin
            cur_x   <= clip_xa;
            cur_y   <= clip_ya;
            rect_xa <= clip_xa;
            rect_xb <= clip_xb;
            rect_yb <= clip_yb;
            state   <= ST_RECT;
          end
        end

        ST_RECT: begin
          if (pixel_valid) begin
            if (cur_x == rect_xb) begin
              if (cur_y == rect_yb) begin
                state <= ST_FINISH;
              end else begin
                cur_x <= rect_xa;
                cur_y <= cur_y + ONE;
              end
            end else begin
              cur_x <= cur_x + ONE;
            end
          end
        end

        ST_LINE: begin
          if (line_advance) begin
            if (at_end) begin
              state <= ST_FINISH;
            end else begin
              line_err <= err_next;
              if (step_x) cur_x <= cur_x + line_sx;
              if (step_y) cur_y <= cur_y + line_sy;
            end
          end
        end

        ST_FINISH: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/primitive_rasterizer.md
Name: primitive_rasterizer

Overview:
- Upstream pixel generator for the framebuffer write stage.
- Accepts one draw command at a time: a filled axis-aligned rectangle or a one-pixel line (Bresenham). Streams clipped pixels as 64-bit {x, y, colour} words into the framebuffer writer's pixel FIFO.
- Honours that FIFO's full flag, so no pixel is ever dropped or duplicated.
- Sits between the command/register interface and the framebuffer writer, in the writer's pixel_data_clock domain.

Parameters:
- SCREEN_WIDTH, 640, number of visible columns; valid x is 0..SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 480, number of visible rows; valid y is 0..SCREEN_HEIGHT-1.

Ports:
- clock  in  1  rasterizer clock; drives the framebuffer writer's pixel_data_clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle command strobe; sampled only when busy=0.
- mode  in  1  0 = filled rectangle, 1 = line.
- x0, y0, x1, y1  in  16 each  signed two's-complement corner/endpoint coordinates.
- colour  in  32  pixel colour.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- pixel_data  out  64  {x[15:0], y[15:0], colour[31:0]}.
- pixel_data_valid  out  1  FIFO write request.
- pixel_fifo_full  in  1  FIFO full flag from the framebuffer writer.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, pixel_data=0, pixel_data_valid=0. Reset mid-command abandons it immediately; no further pixels are emitted.

States: IDLE, SETUP, RECT, LINE, FINISH.
- IDLE:
  - On start=1, latch mode, coordinates and colour; go to SETUP; busy=1 next cycle.
  - start while busy is ignored.
- SETUP (1 cycle):
  - Rect:
    - Normalise so xa=min(x0,x1), xb=max, ya=min(y0,y1), yb=max.
    - Clamp to 0..SCREEN_WIDTH-1 and 0..SCREEN_HEIGHT-1.
    - If xb<0, yb<0, xa>=SCREEN_WIDTH or ya>=SCREEN_HEIGHT, go to FINISH (zero pixels). Otherwise go to RECT with cursor=(xa,ya).
  - Line:
    - dx=|x1-x0|, dy=-|y1-y0|, sx=sign(x1-x0), sy=sign(y1-y0), err=dx+dy.
    - Cursor=(x0,y0). Use 18-bit signed arithmetic throughout. Go to LINE.
- RECT:
  - pixel_data_valid = !pixel_fifo_full (combinational from state and the full input). pixel_data holds the current cursor.
  - Cursor advances only in a cycle where valid=1.
  - Order is row-major: x increments; at x=xb, x returns to xa and y increments.
  - After emitting (xb,yb), go to FINISH.
- LINE, each step:
  - The current point is in-screen iff 0<=x<SCREEN_WIDTH and 0<=y<SCREEN_HEIGHT.
  - If in-screen, valid=!pixel_fifo_full and the step advances only when valid=1.
  - If off-screen, valid=0 and the step advances unconditionally (1 cycle per skipped point).
  - If the point is (x1,y1), go to FINISH after it.
  - Otherwise:
    - e2=2*err.
    - If e2>=dy: err+=dy, x+=sx.
    - If e2<=dx: err+=dx, y+=sy. Both updates may occur in the same step.
  - Both endpoints are inclusive.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. A start in the same cycle as done is ignored.

Timing and limits:
- Latency: start in cycle N gives busy=1 and SETUP in N+1; the earliest valid pixel is N+2.
- Throughput: 1 pixel/cycle while not full.
- pixel_data_valid is never high while pixel_fifo_full=1.
- pixel_data x/y are the unsigned low 16 bits of in-screen coordinates.
- A single-point command (all coordinates equal) emits exactly one pixel.
- Coordinates are limited to |v|<=16383, so no internal overflow can occur.

Test Plan:
1. Rect (2,3)-(4,4), colour 0xFF00FF00, full=0 -> 6 consecutive valid words: (2,3),(3,3),(4,3),(2,4),(3,4),(4,4). First word is 64'h0002_0003_FF00_FF00. done pulses the cycle after the last word; busy falls with it.
2. Same rect, corners swapped (4,4)-(2,3) -> identical 6-word sequence. Same rect with pixel_fifo_full held high for 5 cycles after the 2nd word -> valid=0 throughout the stall, then the remaining 4 words resume; none lost or repeated.
3. Clipped rect (-2,478)-(1,481) -> exactly 4 words: (0,478),(1,478),(0,479),(1,479). Rect (700,10)-(800,20) -> zero valid words; done 2 cycles after start.
4. Line (0,0)-(5,2) -> (0,0),(1,0),(2,1),(3,1),(4,2),(5,2), then done. Line (3,3)-(3,3) -> single word (3,3).
5. Line (-2,0)-(2,0) -> only (0,0),(1,0),(2,0) emitted; valid low for the 2 skipped cycles.
6. Assert reset mid-rect (after 3 words) -> valid, busy and done drop asynchronously. A new start after reset release draws from scratch. A start pulsed while busy=1 -> ignored; pixel count unchanged.
